line_buffer: RTL
================

Name: line_buffer

Overview:
- Upstream neighbour of the convolution stage.
- Takes a raster stream of RGB565 pixels plus hcount/vcount.
- Stores the most recent rows in rotating line RAMs and emits three vertically adjacent pixels per valid input: the `data_in[2:0][15:0]` column the convolution kernel consumes.
- Also emits the matching, re-aligned hcount/vcount/valid.

Parameters:
- HRES, 1280, pixels per line; line RAM depth.
- VRES, 720, lines per frame; used for vcount_out wrap.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- pixel_data_in  input  16  RGB565 pixel.
- hcount_in  input  11  column of pixel_data_in.
- vcount_in  input  10  row of pixel_data_in.
- data_valid_in  input  1  pixel qualifier.
- line_buffer_out  output  3x16 packed [2:0][15:0]  [0]=row vcount_out-1, [1]=row vcount_out, [2]=row vcount_out+1, all at column hcount_out.
- hcount_out  output  11  column of line_buffer_out.
- vcount_out  output  10  centre row of line_buffer_out.
- data_valid_out  output  1  output qualifier.

Behaviour:
- Storage:
  - Four line RAMs, each HRES x 16, simple dual-port, registered read.
  - 2-bit write select wr_sel chooses the RAM being written.
- Write:
  - On clk_in rising edge with data_valid_in=1, write pixel_data_in at address hcount_in into RAM[wr_sel].
  - If additionally hcount_in==HRES-1, wr_sel <= wr_sel+1 (mod 4, wraps 3->0) in the same cycle.
  - wr_sel changes only on a valid last-column pixel.
- Read:
  - Same cycle as the write, address hcount_in is presented to the other three RAMs:
    - RAM[wr_sel+1] is the oldest row, vcount_in-3.
    - RAM[wr_sel+2] is row vcount_in-2.
    - RAM[wr_sel+3] is row vcount_in-1.
  - The RAM being written is never read, so there is no read/write address collision.
  - The RAM-to-output mapping is captured with the read (delayed select), not re-evaluated at output time.
- Latency: exactly 2 cycles, data_valid_in to data_valid_out.
  - Stage 1: RAM read register.
  - Stage 2: output mux/register.
  - hcount, vcount and valid are pipelined through 2 matching stages.
- Output mapping:
  - line_buffer_out[0] = oldest row.
  - line_buffer_out[1] = middle row.
  - line_buffer_out[2] = newest row.
  - hcount_out = hcount_in delayed by 2.
  - vcount_out = (vcount_in-2) mod VRES, delayed by 2. If vcount_in<2, vcount_out = vcount_in+VRES-2.
- Invalid cycles:
  - data_valid_in=0 means no write, no wr_sel change.
  - data_valid_out=0 two cycles later.
  - line_buffer_out, hcount_out and vcount_out hold their last values.
- Frame boundaries:
  - No special handling; wr_sel keeps rotating across frames.
  - At top rows, the out-of-frame taps return the previous frame's bottom rows (or post-reset garbage). Edge handling belongs to the consumer.
- Reset (rst_in=0, asynchronous, any time):
  - wr_sel=0.
  - Both valid pipeline stages=0.
  - data_valid_out=0, hcount_out=0, vcount_out=0, line_buffer_out=0.
  - RAM contents are not cleared.
  - Mid-line reset drops in-flight pixels; the first valid after release writes RAM[0].
- Width rules: hcount/vcount widths are fixed at 11/10 bits; vcount wrap arithmetic is done at 10 bits against VRES.

Decomposition:
- Shared package (shared with convolution): RGB565 pixel typedef, hcount/vcount widths, pipeline latency constant LB_LATENCY=2.
- Sub-module: line_ram. Parameterised depth/width, simple dual-port, 1-cycle registered read; instantiated 4x via generate.
- Rotation, select delay and output mux live in line_buffer.

Test Plan:
All scenarios use HRES=8, VRES=6, and pixel = {vcount[7:0], hcount[7:0]}.
- Reset: assert rst_in=0 asynchronously mid-cycle -> all outputs 0 immediately; wr_sel=0 after release.
- Fill/basic: stream rows 0-2 fully valid, then row 3 pixel h=5 -> 2 cycles later data_valid_out=1, out[0]=16'h0005, out[1]=16'h0105, out[2]=16'h0205, hcount_out=5, vcount_out=1.
- Rotation wrap: continue through row 4 h=0 (wr_sel wrapped to 0) -> out = 16'h0100/16'h0200/16'h0300, vcount_out=2.
- Valid gaps: de-assert data_valid_in for 3 cycles mid-row 3 -> data_valid_out low for exactly those 3 cycles (delayed 2), outputs held, no column skipped or duplicated, wr_sel unchanged.
- vcount wrap: frame 2 row 0 h=2 -> vcount_out=4, out[0]=16'h0302, out[1]=16'h0402, out[2]=16'h0502.
- Reset mid-row: reset at row 3 h=4, then restream from row 0 -> first valid writes RAM[0], no X on outputs, latency still 2.

Source files
------------

// File: rtl/line_buffer_pkg.sv
// rtl/line_buffer_pkg.sv - shared pixel/count types and pipeline constants for line_buffer and convolution
package line_buffer_pkg;

   localparam int HCOUNT_W   = 11;
   localparam int VCOUNT_W   = 10;
   localparam int PIXEL_W    = 16;
   localparam int LB_LATENCY = 2;
   localparam int LB_TAPS    = 3;
   localparam int NUM_LINES  = 4;

   typedef logic [PIXEL_W-1:0]  rgb565_t;
   typedef logic [HCOUNT_W-1:0] hcount_t;
   typedef logic [VCOUNT_W-1:0] vcount_t;
   typedef logic [1:0]          line_sel_t;

   // Row that sits in the middle of the three taps, two rows above the incoming one,
   // wrapped at 10 bits so the first two rows of a frame point at the previous frame's bottom
   function automatic vcount_t centre_row(input vcount_t v, input vcount_t vres);
      vcount_t two;
      two = vcount_t'(2);
      return (v < two) ? (v + vres - two) : (v - two);
   endfunction

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - simple dual-port line RAM with one-cycle registered read
module line_ram #(
   parameter int DEPTH  = 1280,
   parameter int WIDTH  = 16,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage is never cleared; the read register only advances on a read request
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - rotating four-line buffer producing a 3-row pixel column for convolution
module line_buffer
   import line_buffer_pkg::*;
#(
   parameter int HRES = 1280,
   parameter int VRES = 720
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic [15:0]         pixel_data_in,
   input  logic [10:0]         hcount_in,
   input  logic [9:0]          vcount_in,
   input  logic                data_valid_in,
   output logic [2:0][15:0]    line_buffer_out,
   output logic [10:0]         hcount_out,
   output logic [9:0]          vcount_out,
   output logic                data_valid_out
);

   localparam int      ADDR_W   = (HRES > 1) ? $clog2(HRES) : 1;
   localparam hcount_t LAST_COL = hcount_t'(HRES - 1);
   localparam vcount_t VRES_V   = vcount_t'(VRES);

   line_sel_t           wr_sel;
   logic [ADDR_W-1:0]   col_addr;
   rgb565_t             rd_data [NUM_LINES];

   // Stage-1 sideband: travels alongside the RAM read register
   logic                valid_d1;
   line_sel_t           sel_d1;
   hcount_t             hcount_d1;
   vcount_t             vcount_d1;

   line_sel_t           sel_old;
   line_sel_t           sel_mid;
   line_sel_t           sel_new;

   assign col_addr = hcount_in[ADDR_W-1:0];

   // Four line RAMs; only RAM[wr_sel] is written, all are read at the same column
   for (genvar i = 0; i < NUM_LINES; i++) begin : g_ram
      line_ram #(
         .DEPTH  (HRES),
         .WIDTH  (PIXEL_W),
         .ADDR_W (ADDR_W)
      ) u_line_ram (
         .clk     (clk_in),
         .wr_en   (data_valid_in && (wr_sel == line_sel_t'(i))),
         .wr_addr (col_addr),
         .wr_data (pixel_data_in),
         .rd_en   (data_valid_in),
         .rd_addr (col_addr),
         .rd_data (rd_data[i])
      );
   end

   // Advance the write line after the last valid pixel of each row
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_sel <= '0;
      end else if (data_valid_in && (hcount_in == LAST_COL)) begin
         wr_sel <= wr_sel + 2'd1;
      end
   end

   // Capture the line select and counts together with the RAM read so the tap mapping
   // reflects the row being written when the read was issued, not a later rotation
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_d1  <= 1'b0;
         sel_d1    <= '0;
         hcount_d1 <= '0;
         vcount_d1 <= '0;
      end else begin
         valid_d1 <= data_valid_in;
         if (data_valid_in) begin
            sel_d1    <= wr_sel;
            hcount_d1 <= hcount_in;
            vcount_d1 <= centre_row(vcount_in, VRES_V);
         end
      end
   end

   // Oldest/middle/newest rows follow the written line in rotation order
   always_comb begin
      sel_old = sel_d1 + 2'd1;
      sel_mid = sel_d1 + 2'd2;
      sel_new = sel_d1 + 2'd3;
   end

   // Output register: updates only on a valid column, otherwise holds the last column
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         data_valid_out  <= 1'b0;
         hcount_out      <= '0;
         vcount_out      <= '0;
         line_buffer_out <= '0;
      end else begin
         data_valid_out <= valid_d1;
         if (valid_d1) begin
            line_buffer_out[0] <= rd_data[sel_old];
            line_buffer_out[1] <= rd_data[sel_mid];
            line_buffer_out[2] <= rd_data[sel_new];
            hcount_out         <= hcount_d1;
            vcount_out         <= vcount_d1;
         end
      end
   end

endmodule
